// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types: fetch state enum, instruction field positions, HALT opcode, default widths
package cpu_pkg;

   localparam int ADDR_W_DEF  = 4;
   localparam int INSTR_W_DEF = 16;

   localparam int OPC_MSB  = 15;
   localparam int OPC_LSB  = 12;
   localparam int SEL1_MSB = 11;
   localparam int SEL1_LSB = 8;
   localparam int SEL2_MSB = 7;
   localparam int SEL2_LSB = 4;
   localparam int DEST_MSB = 3;
   localparam int DEST_LSB = 0;

   localparam logic [3:0] OPC_HALT = 4'b1111;

   typedef enum logic [1:0] {
      ST_ISSUE = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC, ROM read, one-entry output buffer, redirect squash
// Optional HALT opcode handling enabled by defining INSTR_FETCH_HALT_EN.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF
) (
   input  logic               clock,
   input  logic               reset,
   output logic [ADDR_W-1:0]  rom_addr,
   output logic               rom_ce,
   input  logic [INSTR_W-1:0] rom_data,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic [3:0]         opcode,
   output logic [3:0]         select1,
   output logic [3:0]         select2,
   output logic [3:0]         dest,
   output logic               halted
);

   fetch_state_e       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
   logic               valid_q, valid_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_ISSUE;
         pc_q       <= '0;
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      valid_d    = valid_q;
      case (state_q)
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            instr_d    = rom_data;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + 1'b1;
            state_d    = ST_HOLD;
         end
         ST_HOLD: begin
            if (out_ready) begin
               valid_d = 1'b0;
               state_d = ST_ISSUE;
`ifdef INSTR_FETCH_HALT_EN
               if (instr_q[OPC_MSB:OPC_LSB] == OPC_HALT) state_d = ST_HALT;
`endif
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_ISSUE;
      endcase
      // Redirect wins over everything; a word arriving in WAIT is dropped.
      if (redirect) begin
         pc_d       = redirect_pc;
         valid_d    = 1'b0;
         instr_d    = instr_q;
         instr_pc_d = instr_pc_q;
         state_d    = ST_ISSUE;
      end
   end

   assign rom_ce    = (state_q == ST_ISSUE) && !reset;
   assign rom_addr  = pc_q;
   assign out_valid = valid_q;
   assign instr     = instr_q;
   assign instr_pc  = instr_pc_q;
   assign opcode    = instr_q[OPC_MSB:OPC_LSB];
   assign select1   = instr_q[SEL1_MSB:SEL1_LSB];
   assign select2   = instr_q[SEL2_MSB:SEL2_LSB];
   assign dest      = instr_q[DEST_MSB:DEST_LSB];

`ifdef INSTR_FETCH_HALT_EN
   assign halted = (state_q == ST_HALT);
`else
   assign halted = 1'b0;
`endif

endmodule
